multicycle_controller: RTL and testbench

- Control unit for the 16-bit multi-cycle accumulator CPU; produces every datapath control strobe from the 3-bit opcode the datapath exports.
- Moore FSM, one instruction per 3 cycles (fetch, decode, execute); HLT parks the machine until reset.
- Output names and meanings match the datapath control inputs one-to-one.
- Instruction: IR[15:13] opcode, IR[12:0] absolute address.

---
 rtl/multicycle_controller.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control unit for the 16-bit multi-cycle accumulator CPU. A Moore FSM walks
// each instruction through FETCH -> DECODE -> one execute state, then returns
// to FETCH, so every instruction except HLT takes exactly three cycles. HLT
// parks the machine in HALT until reset.
//
// Instruction format: IR[15:13] opcode, IR[12:0] absolute address.
// Opcodes: 000 LDA, 001 STA, 010 ADD, 011 SUB, 100 AND, 101 JMP, 110 JZ, 111 HLT.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous, active-high reset; forces all outputs to 0
//   opcode[2:0]  in   IR[15:13] from the datapath (valid from DECODE onward)
//   PCWriteCond  out  PC load qualified by ALU zero
//   PCWrite      out  unconditional PC load
//   IorD         out  memory address select: 0=PC, 1=IR[12:0]
//   memRead      out  memory read enable
//   memWrite     out  memory write enable (data=ACC)
//   IRWrite      out  IR load
//   memToAcc     out  ACC source: 0=ALU, 1=MDR
//   accWrite     out  ACC load
//   ALUSrcA      out  0=PC, 1=ACC
//   ALUSrcB      out  0=MDR, 1=constant 1
//   PCSrc        out  0=ALU result, 1=IR[12:0]
//   ALUFunc[1:0] out  ALU operation code
//   halted       out  high while in HALT
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  output logic       PCWriteCond,
  output logic       PCWrite,
  output logic       IorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       IRWrite,
  output logic       memToAcc,
  output logic       accWrite,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       PCSrc,
  output logic [1:0] ALUFunc,
  output logic       halted
);

  // ALU operation codes understood by the datapath.
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_AND   = 2'b10;
  localparam logic [1:0] ALU_PASSA = 2'b11;

  // Instruction opcodes (IR[15:13]).
  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_STA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;
  localparam logic [2:0] OP_JZ  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_LDA_WB  = 3'd2,
    S_STA_MEM = 3'd3,
    S_ALU_WB  = 3'd4,
    S_JMP_EX  = 3'd5,
    S_JZ_EX   = 3'd6,
    S_HALT    = 3'd7
  } state_e;

  // Bundle of every datapath strobe, so the per-state decode reads as a list.
  typedef struct packed {
    logic       pc_write_cond;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_acc;
    logic       acc_write;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       pc_src;
    logic [1:0] alu_func;
    logic       halted;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs, independent of process evaluation order.
  // NOTE: reset is synchronous: it only takes effect on a rising clk edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode.
  // NOTE: every variable written here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    ctrl          = '0;
    ctrl.alu_func = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        // IR <= mem[PC]; PC <= PC + 1 through the ALU.
        ctrl.i_or_d    = 1'b0;
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_func  = ALU_ADD;
        ctrl.pc_src    = 1'b0;
        ctrl.pc_write  = 1'b1;
        state_d        = S_DECODE;
      end

      S_DECODE: begin
        // MDR captures the operand at IR[12:0] while the opcode is decoded,
        // so the execute state can use it without an extra memory cycle.
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
        case (opcode)
          OP_LDA:                 state_d = S_LDA_WB;
          OP_STA:                 state_d = S_STA_MEM;
          OP_ADD, OP_SUB, OP_AND: state_d = S_ALU_WB;
          OP_JMP:                 state_d = S_JMP_EX;
          OP_JZ:                  state_d = S_JZ_EX;
          OP_HLT:                 state_d = S_HALT;
          default:                state_d = S_FETCH;
        endcase
      end

      S_LDA_WB: begin
        ctrl.mem_to_acc = 1'b1;
        ctrl.acc_write  = 1'b1;
        state_d         = S_FETCH;
      end

      S_STA_MEM: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
        state_d        = S_FETCH;
      end

      S_ALU_WB: begin
        // ACC <= ACC op MDR; IR still holds this instruction, so the opcode
        // can select the ALU function directly.
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = 1'b0;
        ctrl.mem_to_acc = 1'b0;
        ctrl.acc_write  = 1'b1;
        case (opcode)
          OP_SUB:  ctrl.alu_func = ALU_SUB;
          OP_AND:  ctrl.alu_func = ALU_AND;
          default: ctrl.alu_func = ALU_ADD;
        endcase
        state_d = S_FETCH;
      end

      S_JMP_EX: begin
        ctrl.pc_src   = 1'b1;
        ctrl.pc_write = 1'b1;
        state_d       = S_FETCH;
      end

      S_JZ_EX: begin
        // Pass ACC through the ALU so its zero flag gates the PC load.
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_func      = ALU_PASSA;
        ctrl.pc_src        = 1'b1;
        ctrl.pc_write_cond = 1'b1;
        state_d            = S_FETCH;
      end

      S_HALT: begin
        ctrl.halted = 1'b1;
        state_d     = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // While rst is high every output is forced low, including halted, so the
  // datapath sees no strobes regardless of the state held before reset.
  assign PCWriteCond = ~rst & ctrl.pc_write_cond;
  assign PCWrite     = ~rst & ctrl.pc_write;
  assign IorD        = ~rst & ctrl.i_or_d;
  assign memRead     = ~rst & ctrl.mem_read;
  assign memWrite    = ~rst & ctrl.mem_write;
  assign IRWrite     = ~rst & ctrl.ir_write;
  assign memToAcc    = ~rst & ctrl.mem_to_acc;
  assign accWrite    = ~rst & ctrl.acc_write;
  assign ALUSrcA     = ~rst & ctrl.alu_src_a;
  assign ALUSrcB     = ~rst & ctrl.alu_src_b;
  assign PCSrc       = ~rst & ctrl.pc_src;
  assign ALUFunc     = rst ? 2'b00 : ctrl.alu_func;
  assign halted      = ~rst & ctrl.halted;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller. A small instruction-level
// model (phase within the current instruction, latched opcode, halt flag)
// predicts the 14-bit control vector every cycle; a compare process checks it
// and the mutual-exclusion invariants on each falling edge. Directed
// instructions additionally pin the vectors against hand-written literals.
//
// Control vector bit order (MSB..LSB):
//   PCWriteCond PCWrite IorD memRead memWrite IRWrite memToAcc accWrite
//   ALUSrcA ALUSrcB PCSrc ALUFunc[1:0] halted
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       PCWriteCond, PCWrite, IorD, memRead, memWrite, IRWrite;
  logic       memToAcc, accWrite, ALUSrcA, ALUSrcB, PCSrc, halted;
  logic [1:0] ALUFunc;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .PCWriteCond(PCWriteCond),
    .PCWrite    (PCWrite),
    .IorD       (IorD),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .IRWrite    (IRWrite),
    .memToAcc   (memToAcc),
    .accWrite   (accWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .PCSrc      (PCSrc),
    .ALUFunc    (ALUFunc),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written control vectors for each step of an instruction.
  localparam logic [13:0] V_ZERO   = 14'b0_0_0_0_0_0_0_0_0_0_0_00_0;
  localparam logic [13:0] V_FETCH  = 14'b0_1_0_1_0_1_0_0_0_1_0_00_0;
  localparam logic [13:0] V_DECODE = 14'b0_0_1_1_0_0_0_0_0_0_0_00_0;
  localparam logic [13:0] V_LDA    = 14'b0_0_0_0_0_0_1_1_0_0_0_00_0;
  localparam logic [13:0] V_STA    = 14'b0_0_1_0_1_0_0_0_0_0_0_00_0;
  localparam logic [13:0] V_ADD    = 14'b0_0_0_0_0_0_0_1_1_0_0_00_0;
  localparam logic [13:0] V_SUB    = 14'b0_0_0_0_0_0_0_1_1_0_0_01_0;
  localparam logic [13:0] V_AND    = 14'b0_0_0_0_0_0_0_1_1_0_0_10_0;
  localparam logic [13:0] V_JMP    = 14'b0_1_0_0_0_0_0_0_0_0_1_00_0;
  localparam logic [13:0] V_JZ     = 14'b1_0_0_0_0_0_0_0_1_0_1_11_0;
  localparam logic [13:0] V_HALT   = 14'b0_0_0_0_0_0_0_0_0_0_0_00_1;

  logic [13:0] act;
  assign act = {PCWriteCond, PCWrite, IorD, memRead, memWrite, IRWrite,
                memToAcc, accWrite, ALUSrcA, ALUSrcB, PCSrc, ALUFunc, halted};

  task automatic check(input string name, input logic [13:0] got,
                       input logic [13:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Instruction-level model: which cycle of the instruction we are in
  // (0 fetch, 1 decode, 2 execute), the opcode seen at decode, and whether a
  // HLT has been decoded since the last reset.
  // ---------------------------------------------------------------------------
  int         m_phase = 0;
  logic [2:0] m_op    = 3'd0;
  bit         m_halt  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_halt  <= 1'b0;
    end else if (!m_halt) begin
      if (m_phase == 1) begin
        m_op <= opcode;
        if (opcode == 3'b111) m_halt <= 1'b1;
        else                  m_phase <= 2;
      end else begin
        m_phase <= (m_phase + 1) % 3;
      end
    end
  end

  function automatic logic [13:0] exec_vec(input logic [2:0] op);
    logic [13:0] tbl [0:7];
    tbl[0] = V_LDA; tbl[1] = V_STA; tbl[2] = V_ADD; tbl[3] = V_SUB;
    tbl[4] = V_AND; tbl[5] = V_JMP; tbl[6] = V_JZ;  tbl[7] = V_HALT;
    return tbl[op];
  endfunction

  function automatic logic [13:0] model_vec();
    if (rst)          return V_ZERO;
    if (m_halt)       return V_HALT;
    if (m_phase == 0) return V_FETCH;
    if (m_phase == 1) return V_DECODE;
    return exec_vec(m_op);
  endfunction

  // Compare process: model vector plus invariants, every cycle.
  always @(negedge clk) begin
    bit is_exec_acc;
    is_exec_acc = !rst && !m_halt && m_phase == 2 &&
                  (m_op == 3'd0 || m_op == 3'd2 || m_op == 3'd3 || m_op == 3'd4);
    check("model",        act, model_vec());
    check("inv_rd_wr",    14'(memRead & memWrite), 14'd0);
    check("inv_pcw_cond", 14'(PCWrite & PCWriteCond), 14'd0);
    check("inv_irwrite",  14'(IRWrite & !(!rst && !m_halt && m_phase == 0)), 14'd0);
    check("inv_accwrite", 14'(accWrite & !is_exec_acc), 14'd0);
  end

  // ---------------------------------------------------------------------------
  // Stimulus: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one instruction starting in a FETCH cycle, pinning all three vectors.
  task automatic instr_lit(input string name, input logic [2:0] op,
                           input logic [13:0] exec_exp);
    opcode = op;
    @(negedge clk); check({name, "_fetch"}, act, V_FETCH);
    tick();
    @(negedge clk); check({name, "_decode"}, act, V_DECODE);
    tick();
    @(negedge clk); check({name, "_exec"}, act, exec_exp);
    tick();
  endtask

  task automatic instr(input logic [2:0] op);
    opcode = op;
    repeat (3) tick();
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 3'd0;

    // Two reset edges; outputs must be all zero throughout.
    @(negedge clk); check("reset_0", act, V_ZERO);
    tick();
    @(negedge clk); check("reset_1", act, V_ZERO);
    tick();
    rst = 1'b0;

    // Directed instructions, each pinned against literal vectors.
    instr_lit("lda", 3'b000, V_LDA);
    instr_lit("sub", 3'b011, V_SUB);
    instr_lit("add", 3'b010, V_ADD);
    instr_lit("and", 3'b100, V_AND);
    instr_lit("sta", 3'b001, V_STA);
    instr_lit("jz",  3'b110, V_JZ);
    instr_lit("jmp", 3'b101, V_JMP);
    instr_lit("lda2", 3'b000, V_LDA);

    // HLT: halted from the 3rd cycle, held for 20 cycles.
    opcode = 3'b111;
    @(negedge clk); check("hlt_fetch", act, V_FETCH);
    tick();
    @(negedge clk); check("hlt_decode", act, V_DECODE);
    tick();
    for (int i = 0; i < 20; i++) begin
      opcode = 3'(i);
      @(negedge clk); check("hlt_hold", act, V_HALT);
      tick();
    end

    // One-cycle reset out of HALT, then FETCH resumes.
    rst = 1'b1;
    @(negedge clk); check("hlt_reset", act, V_ZERO);
    tick();
    rst = 1'b0;
    instr_lit("after_hlt", 3'b010, V_ADD);

    // Reset during DECODE of an ADD: no accWrite, FETCH follows.
    opcode = 3'b010;
    @(negedge clk); check("mid_fetch", act, V_FETCH);
    tick();
    rst = 1'b1;
    @(negedge clk); check("mid_reset", act, V_ZERO);
    tick();
    rst = 1'b0;
    @(negedge clk); check("mid_refetch", act, V_FETCH);
    // Finish this instruction as an ADD so the stream stays aligned.
    repeat (3) tick();

    // Random stream of non-HLT instructions, checked by the model.
    for (int i = 0; i < 1000; i++) begin
      instr(3'($urandom_range(0, 6)));
    end

    // Final HLT from the random stream's end.
    instr(3'b111);
    @(negedge clk); check("final_halt", act, V_HALT);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
